// File: rtl/bitcount_seg7_scan.sv
// Display stage for the 4-bit bit counter: multiplexed common-anode 4-digit 7-segment driver.
// Shows the value as decimal with leading zero blanked, or as one hex digit, latched once per frame.
module bitcount_seg7_scan #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] in_count,
   input  logic       hex_mode,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_start
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);

   typedef enum logic [1:0] {
      SLOT0 = 2'd0,
      SLOT1 = 2'd1,
      SLOT2 = 2'd2,
      SLOT3 = 2'd3
   } slot_e;

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg7_encode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         4'hF:    s = 7'b0001110;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Input never exceeds 15, so the units digit needs at most one subtraction.
   function automatic logic [3:0] dec_units(input logic [3:0] v);
      logic [3:0] u;
      if (v >= 4'd10) begin
         u = v - 4'd10;
      end else begin
         u = v;
      end
      return u;
   endfunction

   logic [PW-1:0] presc_r;
   slot_e         digit_r;
   slot_e         digit_next_s;
   logic [3:0]    frame_val_r;
   logic          frame_hex_r;
   logic          tick_s;
   logic          latch_s;
   logic          blank_s;
   logic          show_s;
   logic [3:0]    glyph_s;
   logic [3:0]    an_next_s;
   logic [6:0]    seg_next_s;
   logic [3:0]    an_r;
   logic [6:0]    seg_r;
   logic          dp_r;
   logic          frame_start_r;

   assign tick_s  = (presc_r == PRESC_LAST);
   assign latch_s = tick_s && (digit_r == SLOT3);
   assign blank_s = (presc_r < BLANK_END);

   // Slot prescaler and once-per-frame value/mode latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_r     <= {PW{1'b0}};
         frame_val_r <= 4'd0;
         frame_hex_r <= 1'b0;
      end else begin
         if (tick_s) begin
            presc_r <= {PW{1'b0}};
         end else begin
            presc_r <= presc_r + PW'(1'b1);
         end
         if (latch_s) begin
            frame_val_r <= in_count;
            frame_hex_r <= hex_mode;
         end else begin
            frame_val_r <= frame_val_r;
            frame_hex_r <= frame_hex_r;
         end
      end
   end

   // Slot FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         digit_r <= SLOT0;
      end else begin
         digit_r <= digit_next_s;
      end
   end

   // Slot FSM next state: rotate through the four digits on each prescaler wrap.
   always_comb begin
      digit_next_s = digit_r;
      if (tick_s) begin
         case (digit_r)
            SLOT0:   digit_next_s = SLOT1;
            SLOT1:   digit_next_s = SLOT2;
            SLOT2:   digit_next_s = SLOT3;
            SLOT3:   digit_next_s = SLOT0;
            default: digit_next_s = SLOT0;
         endcase
      end else begin
         digit_next_s = digit_r;
      end
   end

   // Slot FSM outputs: pick the glyph for this slot and gate it with the anti-ghost window.
   always_comb begin
      show_s     = 1'b0;
      glyph_s    = 4'd0;
      an_next_s  = 4'b1111;
      seg_next_s = 7'b1111111;
      case (digit_r)
         SLOT0: begin
            show_s = 1'b1;
            if (frame_hex_r) begin
               glyph_s = frame_val_r;
            end else begin
               glyph_s = dec_units(frame_val_r);
            end
         end
         SLOT1: begin
            glyph_s = 4'd1;
            if (!frame_hex_r && (frame_val_r >= 4'd10)) begin
               show_s = 1'b1;
            end else begin
               show_s = 1'b0;
            end
         end
         default: begin
            show_s  = 1'b0;
            glyph_s = 4'd0;
         end
      endcase
      if (show_s && !blank_s) begin
         an_next_s  = ~(4'b0001 << digit_r);
         seg_next_s = seg7_encode(glyph_s);
      end else begin
         an_next_s  = 4'b1111;
         seg_next_s = 7'b1111111;
      end
   end

   // Output registers keep the pins glitch-free with a fixed one-cycle latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_r          <= 4'b1111;
         seg_r         <= 7'b1111111;
         dp_r          <= 1'b1;
         frame_start_r <= 1'b0;
      end else begin
         an_r          <= an_next_s;
         seg_r         <= seg_next_s;
         dp_r          <= 1'b1;
         frame_start_r <= latch_s;
      end
   end

   assign an          = an_r;
   assign seg         = seg_r;
   assign dp          = dp_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_bitcount_seg7_scan.sv
// Directed bench for bitcount_seg7_scan with a short refresh period.
// Table vectors cover glyphs and digit modes; hand sequences cover latching and mid-scan reset.
module tb_bitcount_seg7_scan;

   localparam int RD = 4;
   localparam int BC = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in_count;
   logic       hex_mode;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_start;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic [3:0] cnt;
      logic       hex;
      logic [3:0] an0;
      logic [6:0] seg0;
      logic [3:0] an1;
      logic [6:0] seg1;
   } vec_t;

   vec_t vecs[20];

   bitcount_seg7_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_count    (in_count),
      .hex_mode    (hex_mode),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ef);
      chk($sformatf("%s an", name), {3'b000, an}, {3'b000, ea});
      chk($sformatf("%s seg", name), seg, es);
      chk($sformatf("%s dp", name), {6'b000000, dp}, 7'b0000001);
      chk($sformatf("%s frame_start", name), {6'b000000, frame_start}, {6'b000000, ef});
   endtask

   task automatic wait_frame(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc();
         if (frame_start === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s frame_start: got none expected pulse within 40 cycles", name);
      end
   endtask

   // Called at the frame_start cycle; checks the 16 output cycles of the frame that follows.
   task automatic check_frame(input string name, input logic [3:0] a0, input logic [6:0] s0,
                              input logic [3:0] a1, input logic [6:0] s1);
      logic [3:0] ea;
      logic [6:0] es;
      for (int k = 1; k <= 16; k++) begin
         int slot;
         int pos;
         cyc();
         slot = (k - 1) / 4;
         pos  = (k - 1) % 4;
         ea = 4'b1111;
         es = 7'b1111111;
         if (pos != 0 && slot == 0) begin
            ea = a0;
            es = s0;
         end else if (pos != 0 && slot == 1) begin
            ea = a1;
            es = s1;
         end
         chk_out($sformatf("%s k%0d", name, k), ea, es, (k == 16));
      end
   endtask

   initial begin
      vecs[0]  = '{4'd12, 1'b0, 4'b1110, 7'b0100100, 4'b1101, 7'b1111001};
      vecs[1]  = '{4'd7,  1'b0, 4'b1110, 7'b1111000, 4'b1111, 7'b1111111};
      vecs[2]  = '{4'd11, 1'b1, 4'b1110, 7'b0000011, 4'b1111, 7'b1111111};
      vecs[3]  = '{4'd9,  1'b0, 4'b1110, 7'b0010000, 4'b1111, 7'b1111111};
      vecs[4]  = '{4'd10, 1'b0, 4'b1110, 7'b1000000, 4'b1101, 7'b1111001};
      vecs[5]  = '{4'd15, 1'b0, 4'b1110, 7'b0010010, 4'b1101, 7'b1111001};
      vecs[6]  = '{4'd0,  1'b0, 4'b1110, 7'b1000000, 4'b1111, 7'b1111111};
      vecs[7]  = '{4'd15, 1'b1, 4'b1110, 7'b0001110, 4'b1111, 7'b1111111};
      vecs[8]  = '{4'd10, 1'b1, 4'b1110, 7'b0001000, 4'b1111, 7'b1111111};
      vecs[9]  = '{4'd12, 1'b1, 4'b1110, 7'b1000110, 4'b1111, 7'b1111111};
      vecs[10] = '{4'd13, 1'b1, 4'b1110, 7'b0100001, 4'b1111, 7'b1111111};
      vecs[11] = '{4'd14, 1'b1, 4'b1110, 7'b0000110, 4'b1111, 7'b1111111};
      vecs[12] = '{4'd4,  1'b0, 4'b1110, 7'b0011001, 4'b1111, 7'b1111111};
      vecs[13] = '{4'd6,  1'b1, 4'b1110, 7'b0000010, 4'b1111, 7'b1111111};
      vecs[14] = '{4'd8,  1'b0, 4'b1110, 7'b0000000, 4'b1111, 7'b1111111};
      vecs[15] = '{4'd1,  1'b0, 4'b1110, 7'b1111001, 4'b1111, 7'b1111111};
      vecs[16] = '{4'd2,  1'b1, 4'b1110, 7'b0100100, 4'b1111, 7'b1111111};
      vecs[17] = '{4'd5,  1'b1, 4'b1110, 7'b0010010, 4'b1111, 7'b1111111};
      vecs[18] = '{4'd3,  1'b1, 4'b1110, 7'b0110000, 4'b1111, 7'b1111111};
      vecs[19] = '{4'd11, 1'b0, 4'b1110, 7'b1111001, 4'b1101, 7'b1111001};

      rst      = 1'b1;
      in_count = 4'd12;
      hex_mode = 1'b0;

      // Reset held three cycles, then one more cycle of blank output.
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_out($sformatf("reset c%0d", i), 4'b1111, 7'b1111111, 1'b0);
      end
      rst = 1'b0;
      cyc();
      chk_out("post-reset", 4'b1111, 7'b1111111, 1'b0);
      cyc();
      chk_out("pre-latch zero", 4'b1110, 7'b1000000, 1'b0);

      for (int v = 0; v < 20; v++) begin
         in_count = vecs[v].cnt;
         hex_mode = vecs[v].hex;
         wait_frame($sformatf("vec%0d", v));
         check_frame($sformatf("vec%0d", v), vecs[v].an0, vecs[v].seg0, vecs[v].an1, vecs[v].seg1);
      end

      // Input changes mid-frame must wait for the next frame boundary.
      in_count = 4'd3;
      hex_mode = 1'b0;
      wait_frame("latch3");
      cyc();
      in_count = 4'd5;
      for (int k = 2; k <= 4; k++) begin
         cyc();
         chk_out($sformatf("hold3 k%0d", k), 4'b1110, 7'b0110000, 1'b0);
      end
      cyc();
      cyc();
      in_count = 4'd9;
      chk_out("hold3 slot1", 4'b1111, 7'b1111111, 1'b0);
      for (int k = 7; k <= 16; k++) cyc();
      chk_out("latch9 pulse", 4'b1111, 7'b1111111, 1'b1);
      cyc();
      chk_out("latch9 blank", 4'b1111, 7'b1111111, 1'b0);
      cyc();
      in_count = 4'd12;
      chk_out("show9 k2", 4'b1110, 7'b0010000, 1'b0);
      cyc();
      chk_out("show9 k3", 4'b1110, 7'b0010000, 1'b0);
      cyc();
      chk_out("show9 k4", 4'b1110, 7'b0010000, 1'b0);
      cyc();
      cyc();
      chk_out("show9 slot1", 4'b1111, 7'b1111111, 1'b0);

      // Reset pulsed during slot 2 restarts the scan and clears the latched value.
      cyc();
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      chk_out("midreset", 4'b1111, 7'b1111111, 1'b0);
      rst = 1'b0;
      cyc();
      chk_out("midreset r1", 4'b1111, 7'b1111111, 1'b0);
      for (int k = 2; k <= 16; k++) begin
         logic [3:0] ea;
         logic [6:0] es;
         cyc();
         ea = 4'b1111;
         es = 7'b1111111;
         if (k >= 2 && k <= 4) begin
            ea = 4'b1110;
            es = 7'b1000000;
         end
         chk_out($sformatf("midreset r%0d", k), ea, es, (k == 16));
      end
      cyc();
      chk_out("relatch blank", 4'b1111, 7'b1111111, 1'b0);
      cyc();
      chk_out("relatch slot0", 4'b1110, 7'b0100100, 1'b0);
      for (int k = 19; k <= 22; k++) cyc();
      chk_out("relatch slot1", 4'b1101, 7'b1111001, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
